sync_fifo_flex: RTL and testbench

Single-clock, parametrised FIFO: the same-clock-domain successor to our dual-clock FIFO, for buffering between blocks that share one clock. It adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. First-word-fall-through read mode is selectable at compile time.

---
 rtl/sync_fifo_flex.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_flex.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
//
// Single-clock FIFO with an occupancy count, programmable almost-full and
// almost-empty flags, and sticky overflow/underflow flags.
//
// Compile-time option:
//   SYN_FIFO_FWFT_EN  defined   -> first-word-fall-through: rdata shows the head
//                                  word combinationally while the FIFO is not
//                                  empty; rinc pops it.
//                     undefined -> standard mode: rdata is registered and loaded
//                                  on the edge that accepts a read.
//
// Parameters:
//   WIDTH     data word width
//   DEPTH     number of entries (power of two, >= 4)
//   AF_LEVEL  walmost_full  when level >= AF_LEVEL
//   AE_LEVEL  ralmost_empty when level <= AE_LEVEL
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rstn           asynchronous active-low reset
//   winc / wdata   write request and data
//   rinc           read request
//   err_clr        synchronous clear of overflow/underflow
//   rdata          read data
//   wfull/rempty   full / empty
//   walmost_full   level >= AF_LEVEL
//   ralmost_empty  level <= AE_LEVEL
//   level          occupancy 0..DEPTH
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flex #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  winc,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  rinc,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_THR   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_en, rd_en;

  // Status is a pure function of the registered pointers, so no input reaches
  // a flag combinationally. The MSB of each pointer is the wrap bit: equal
  // pointers mean empty, pointers differing only in the wrap bit mean full.
  assign rempty        = (wptr_q == rptr_q);
  assign wfull         = ((wptr_q ^ rptr_q) == FULL_XOR);
  assign level         = wptr_q - rptr_q;
  assign walmost_full  = (level >= AF_THR);
  assign ralmost_empty = (level <= AE_THR);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // Acceptance uses pre-edge status only: a read at full and a write at empty
  // are still accepted alongside the opposite operation, the other is dropped.
  assign wr_en = winc && !wfull;
  assign rd_en = rinc && !rempty;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
    // A new error on the clearing edge wins over the clear.
    overflow_d  = (overflow_q  && !err_clr) || (winc && wfull);
    underflow_d = (underflow_q && !err_clr) || (rinc && rempty);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through the pointers, which are reset, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
  end

`ifdef SYN_FIFO_FWFT_EN
  // Head word falls through; forced to zero while empty so the reset value
  // of rdata is defined.
  always_comb begin
    rdata = '0;
    if (!rempty) rdata = mem[rptr_q[ADDR_WIDTH-1:0]];
  end
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // rdata holds except on an accepted read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[rptr_q[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
//
// Self-checking bench for sync_fifo_flex (WIDTH=8, DEPTH=16, default flag
// levels). A queue model holds the words expected to come out; every cycle the
// bench compares level, flags, error bits and read data against it. A short
// table of hand-computed vectors is applied first, followed by sequences for
// fill/drain, overflow/underflow, wrap, simultaneous access and reset.
// Works in both read modes (SYN_FIFO_FWFT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             winc, rinc, err_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             wfull, rempty, walmost_full, ralmost_empty;
  logic [4:0]       level;
  logic             overflow, underflow;

  sync_fifo_flex #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .err_clr       (err_clr),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  // Scoreboard / reference model
  logic [WIDTH-1:0] sb[$];
  logic             m_ovf, m_udf;
  logic [WIDTH-1:0] m_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state();
    check("level",         32'(level),         32'(sb.size()));
    check("rempty",        32'(rempty),        32'(sb.size() == 0));
    check("wfull",         32'(wfull),         32'(sb.size() == DEPTH));
    check("walmost_full",  32'(walmost_full),  32'(sb.size() >= AF));
    check("ralmost_empty", 32'(ralmost_empty), 32'(sb.size() <= AE));
    check("overflow",      32'(overflow),      32'(m_ovf));
    check("underflow",     32'(underflow),     32'(m_udf));
`ifndef SYN_FIFO_FWFT_EN
    check("rdata_hold",    32'(rdata),         32'(m_rdata));
`endif
  endtask

  // One clock cycle: drive at negedge, update model at the edge, check #1 later.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
    logic m_full, m_empty, wr_ok, rd_ok;
    logic [WIDTH-1:0] exp_d;
    @(negedge clk);
    winc = w; wdata = d; rinc = r; err_clr = c;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    wr_ok   = w && !m_full;
    rd_ok   = r && !m_empty;
`ifdef SYN_FIFO_FWFT_EN
    #1;
    if (!m_empty) check("fwft_head", 32'(rdata), 32'(sb[0]));
`endif
    @(posedge clk);
    #1;
    if (rd_ok) begin
      exp_d   = sb.pop_front();
      m_rdata = exp_d;
    end
    if (wr_ok) sb.push_back(d);
    m_ovf = (m_ovf && !c) || (w && m_full);
    m_udf = (m_udf && !c) || (r && m_empty);
    check_state();
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = '0;
  endtask

  typedef struct {
    logic             w;
    logic [WIDTH-1:0] d;
    logic             r;
    logic             c;
    int               exp_level;
    logic             exp_ovf;
    logic             exp_udf;
  } vec_t;

  vec_t tbl[12];
  logic [WIDTH-1:0] pat;

  initial begin
    // Hand-computed vectors starting from an empty FIFO.
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0}; // idle
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1}; // read empty
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0}; // clear
    tbl[3]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0}; // both
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1}; // both at empty
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0}; // clear
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    rstn = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset state after 3 idle cycles
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("rst_level", 32'(level), 32'd0);
`ifndef SYN_FIFO_FWFT_EN
    check("rst_rdata", 32'(rdata), 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      check($sformatf("tbl%0d_level", i), 32'(level),     32'(tbl[i].exp_level));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow),  32'(tbl[i].exp_ovf));
      check($sformatf("tbl%0d_udf", i),   32'(underflow), 32'(tbl[i].exp_udf));
    end

    // Fill with 0x01..0x10, then overflow with 0xFF
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_wfull", 32'(wfull), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);

    // Drain: data must be 0x01..0x10 (0xFF never stored)
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYN_FIFO_FWFT_EN
      check("drain_rdata", 32'(rdata), 32'(i));
`endif
    end
    check("drain_rempty", 32'(rempty), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_set", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow),  32'd0);
    check("clr_udf", 32'(underflow), 32'd0);

    // Level 5, then 40 cycles of simultaneous access across pointer wrap
    pat = 8'h40;
    for (int i = 0; i < 5; i++) begin step(1'b1, pat, 1'b0, 1'b0); pat++; end
    for (int i = 0; i < 40; i++) begin step(1'b1, pat, 1'b1, 1'b0); pat++; end
    check("steady_level", 32'(level), 32'd5);
    check("steady_ovf",   32'(overflow),  32'd0);
    check("steady_udf",   32'(underflow), 32'd0);

    // Fill, then both high at full: read wins, overflow sets
    while (sb.size() < DEPTH) begin step(1'b1, pat, 1'b0, 1'b0); pat++; end
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_both_level", 32'(level), 32'd15);
    check("full_both_ovf",   32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Drain, then both high at empty: write wins, underflow sets
    while (sb.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("empty_both_level", 32'(level), 32'd1);
    check("empty_both_udf",   32'(underflow), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Burst to level 9, then async reset in the middle of the cycle
    for (int i = 0; i < 9; i++) begin step(1'b1, pat, 1'b0, 1'b0); pat++; end
    @(negedge clk);
    winc = 1'b1; wdata = pat;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_state();
`ifndef SYN_FIFO_FWFT_EN
    check("arst_rdata", 32'(rdata), 32'd0);
`endif
    winc = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_hold_level", 32'(level), 32'd0);
    rstn = 1'b1;

    // Resume with 0xA5
    step(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef SYN_FIFO_FWFT_EN
    check("fwft_a5", 32'(rdata), 32'hA5);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYN_FIFO_FWFT_EN
    check("std_a5", 32'(rdata), 32'hA5);
`endif
    check("final_empty", 32'(rempty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
